// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter
//   Shares one downstream valid/ready channel between NUM_REQ requesters.
//   Arbitration is round-robin between bursts; once a burst starts (a beat
//   accepted with last=0) the grant stays with that requester until its last
//   beat is accepted. The output is registered through one pipeline stage.
//
// Ports
//   clk_i        clock
//   arst_ni      asynchronous reset, active-low
//   req_valid_i  per-requester beat valid
//   req_data_i   packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last_i   per-requester last-beat-of-burst flag
//   req_ready_o  per-requester beat accepted (one-hot or zero, combinational)
//   out_valid_o  registered output beat valid
//   out_data_o   registered output payload
//   out_last_o   registered last flag
//   out_id_o     index of the requester that sourced the output beat
//   out_ready_i  downstream accepts the output beat
//   busy_o       high while a burst holds the grant
module rr_burst_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                          clk_i,
    input  logic                          arst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          out_valid_o,
    output logic [DATA_WIDTH-1:0]         out_data_o,
    output logic                          out_last_o,
    output logic [$clog2(NUM_REQ)-1:0]    out_id_o,
    input  logic                          out_ready_i,
    output logic                          busy_o
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  owner_q, owner_d;

    logic            stage_free;
    logic [IDW-1:0]  sel;
    logic            sel_valid;
    logic            accept;
    logic [IDW:0]    cand;
    logic [DATA_WIDTH-1:0] sel_data;
    logic            sel_last;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
        if (idx == IDW'(NUM_REQ - 1)) begin
            return '0;
        end
        return idx + IDW'(1);
    endfunction

    assign stage_free = ~out_valid_o | out_ready_i;

    // Requester selection. In LOCKED only the owner is looked at, so the
    // owner's ready never depends on any other requester's valid.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        cand      = '0;
        if (state_q == LOCKED) begin
            sel       = owner_q;
            sel_valid = req_valid_i[owner_q];
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                // Modulo by conditional subtract keeps non-power-of-2
                // NUM_REQ from ever producing an index >= NUM_REQ.
                cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
                if (cand >= (IDW+1)'(NUM_REQ)) begin
                    cand = cand - (IDW+1)'(NUM_REQ);
                end
                if (!sel_valid && req_valid_i[cand[IDW-1:0]]) begin
                    sel       = cand[IDW-1:0];
                    sel_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == sel) begin
                sel_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign sel_last = req_last_i[sel];
    assign accept   = sel_valid & stage_free;

    // State register
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    // Next-state logic; rr_ptr only moves when a last beat is accepted.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (sel_last) begin
                        rr_ptr_d = wrap_inc(sel);
                    end else begin
                        state_d = LOCKED;
                        owner_d = sel;
                    end
                end
                LOCKED: begin
                    if (sel_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = wrap_inc(owner_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs; ready is forced low while reset is asserted because the
    // cleared output stage would otherwise look free.
    always_comb begin
        req_ready_o = '0;
        if (arst_ni && accept) begin
            req_ready_o[sel] = 1'b1;
        end
        busy_o = (state_q == LOCKED);
    end

    // Output pipeline stage
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            out_id_o    <= '0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            out_data_o  <= sel_data;
            out_last_o  <= sel_last;
            out_id_o    <= sel;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Shares one downstream valid/ready channel (e.g. a common write-back or memory-request bus) between NUM_REQ upstream requesters.
- Uses round-robin selection.
- Locks the grant to one requester for the whole multi-beat burst, delimited by a last flag.
- Registers the output through a single pipeline stage.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2 or more.
- DATA_WIDTH, 64, payload width per beat.

Ports:
- clk_i  input  1  clock.
- arst_ni  input  1  asynchronous reset, active-low.
- req_valid_i  input  NUM_REQ  per-requester beat valid.
- req_data_i  input  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last_i  input  NUM_REQ  per-requester last-beat-of-burst flag.
- req_ready_o  output  NUM_REQ  per-requester beat accepted, one-hot or zero.
- out_valid_o  output  1  registered output beat valid.
- out_data_o  output  DATA_WIDTH  registered output payload.
- out_last_o  output  1  registered last flag.
- out_id_o  output  $clog2(NUM_REQ)  index of the requester that sourced the output beat.
- out_ready_i  input  1  downstream accepts the output beat.
- busy_o  output  1  high while in LOCKED state.

Behaviour:
- Reset is asynchronous, active-low (arst_ni); clock is clk_i.
- Reset values:
  - out_valid_o=0, out_data_o=0, out_last_o=0, out_id_o=0, busy_o=0.
  - state=IDLE, rr_ptr=0, owner=0.
  - req_ready_o=0 while in reset.
- Stage free: stage_free = ~out_valid_o | out_ready_i.
- Selection:
  - IDLE: sel = first i with req_valid_i[i]=1, scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - LOCKED: sel = owner, considered only if req_valid_i[owner]=1.
- Ready: req_ready_o[sel] = stage_free & req_valid_i[sel]; all other bits are 0. req_ready_o is purely combinational; req_ready_o[i] has no combinational path from req_valid_i[j] for j≠i in LOCKED.
- Beat accept occurs when req_valid_i[sel] & req_ready_o[sel]. On the next clock edge:
  - out_valid_o=1.
  - out_data_o, out_last_o and out_id_o take the accepted payload, flag and index.
- If out_ready_i=1 and no beat is accepted, out_valid_o clears next cycle. out_data_o, out_last_o and out_id_o hold their values.
- Latency is 1 cycle from accept to out_valid_o. Sustained throughput is 1 beat/cycle when out_ready_i is held high.
- FSM:
  - IDLE -> LOCKED on an accepted beat with last=0; owner <= sel.
  - IDLE stays IDLE on an accepted beat with last=1; rr_ptr <= (sel+1) mod NUM_REQ.
  - LOCKED -> IDLE on an accepted owner beat with last=1; rr_ptr <= (owner+1) mod NUM_REQ.
  - LOCKED otherwise holds, including while the owner deasserts valid mid-burst. No other requester is served, there is no timeout, and out_valid_o drains normally.
- rr_ptr changes only on accepted last beats. Wrap: owner NUM_REQ-1 makes rr_ptr=0.
- Backpressure: while out_valid_o=1 and out_ready_i=0, all req_ready_o=0 and the output register holds stable (data, last and id must not change).
- Simultaneous drain and accept in one cycle are legal; the output register reloads without a bubble.
- Reset mid-burst aborts the burst: state=IDLE, rr_ptr=0 and the pending output beat is discarded. There is no recovery of partial bursts.
- Arithmetic: all index math is modulo NUM_REQ. For non-power-of-2 NUM_REQ, indices ≥ NUM_REQ never occur.

Test Plan:
- Reset/idle: assert arst_ni=0 mid-traffic -> all outputs 0 immediately. After release with no valid: req_ready_o=0, out_valid_o=0, busy_o=0.
- Round-robin fairness, NUM_REQ=4: all four requesters send continuous single-beat (last=1) traffic with out_ready_i=1 -> out_id_o sequence 0,1,2,3,0,1,…, one beat per cycle, first out_valid_o 1 cycle after first accept.
- Burst lock: req1 sends 3 beats (last on beat 3) while req0, req2 and req3 are all valid -> out_id_o=1,1,1 then 2,3,0. busy_o=1 from the cycle after beat 1 through beat 3 acceptance.
- Mid-burst gap: req2 sends beat1 (last=0), drops valid for 4 cycles, then sends a last beat, while req0 is valid throughout -> req_ready_o[0] stays 0 during the gap. req0 is served only after req2's last beat; rr_ptr becomes 3.
- Backpressure: hold out_ready_i=0 for 5 cycles with out_valid_o=1 -> out_data_o, out_last_o and out_id_o stable and req_ready_o=0. On out_ready_i=1, the next beat loads in the same cycle with no bubble.
- Wrap and reset-abort: req3 single beat -> rr_ptr=0, so req0 wins over req1 next. Start a 4-beat req1 burst, reset after beat 2 -> busy_o=0, and the next arbitration starts from requester 0.
